// File: rtl/conv_layer_sequencer_pkg.sv
// Shared definitions for the conv-layer parameter sequencer: geometry, derived
// beat counts and the state codes presented to the conv unit.
package conv_layer_sequencer_pkg;

    localparam int CONV_IN_NUM  = 9;
    localparam int CONV_OUT_NUM = 18;
    localparam int WEIGHT_WIDTH = 8;
    localparam int BIAS_WIDTH   = 16;
    localparam int LOAD_WIDTH   = 72;

    localparam int W_BUS_W = CONV_IN_NUM * WEIGHT_WIDTH * CONV_OUT_NUM;
    localparam int B_BUS_W = BIAS_WIDTH * CONV_OUT_NUM;
    localparam int W_BEATS = W_BUS_W / LOAD_WIDTH;
    localparam int B_BEATS = B_BUS_W / LOAD_WIDTH;

    // Codes 6 and 7 are never produced; the FSM falls back to IDLE if seen.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_RUN_DW = 3'd3,
        ST_RUN_PW = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Beat counter width; at least one bit even for a single-beat bus.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/conv_layer_sequencer_assembler.sv
// Collects BEATS stream beats into one wide bus. Beat k lands in slice k;
// slices not yet rewritten keep the previous tile's contents.
module conv_layer_sequencer_assembler
    import conv_layer_sequencer_pkg::*;
#(
    parameter int BEATS  = 18,
    parameter int BEAT_W = 72
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    s_valid,
    input  logic [BEAT_W-1:0]       s_data,
    output logic [BEATS*BEAT_W-1:0] bus,
    output logic                    last
);

    localparam int CNT_W = cnt_width(BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BEATS*BEAT_W-1:0] bus_q, bus_d;
    logic                    accept;

    // Accepted beat writes the slice under the counter; counter wraps after the last beat.
    always_comb begin
        accept = en & s_valid;
        last   = accept && (cnt_q == CNT_LAST);
        cnt_d  = cnt_q;
        bus_d  = bus_q;
        if (accept) begin
            bus_d[int'(cnt_q)*BEAT_W +: BEAT_W] = s_data;
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter and bus storage; reset discards any partial load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            bus_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            bus_q <= bus_d;
        end
    end

    assign bus = bus_q;

endmodule

// File: rtl/conv_layer_sequencer.sv
// Drives the conv unit through LOAD_W -> LOAD_B -> RUN for each output-channel
// tile of a layer, streaming weights and biases from the parameter DMA.
module conv_layer_sequencer
    import conv_layer_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode_pw,
    input  logic [7:0]            tile_num,
    input  logic [LOAD_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [W_BUS_W-1:0]    Conv_weight_in,
    output logic                  Conv_weight_valid_in,
    output logic [B_BUS_W-1:0]    Conv_bias_in,
    output logic                  Conv_bias_valid_in,
    output logic [2:0]            current_state,
    input  logic                  state_rst,
    output logic [7:0]            tile_idx,
    output logic                  busy,
    output logic                  done
);

    state_e     state_q, state_d;
    logic       mode_pw_q, mode_pw_d;
    logic [7:0] tile_num_q, tile_num_d;
    logic [7:0] tile_idx_q, tile_idx_d;
    logic       w_vld_q, w_vld_d;
    logic       b_vld_q, b_vld_d;
    logic       w_en, b_en, w_last, b_last;

    conv_layer_sequencer_assembler #(.BEATS(W_BEATS), .BEAT_W(LOAD_WIDTH)) u_weights (
        .clk     (clk),
        .rst     (rst),
        .en      (w_en),
        .s_valid (s_valid),
        .s_data  (s_data),
        .bus     (Conv_weight_in),
        .last    (w_last)
    );

    conv_layer_sequencer_assembler #(.BEATS(B_BEATS), .BEAT_W(LOAD_WIDTH)) u_biases (
        .clk     (clk),
        .rst     (rst),
        .en      (b_en),
        .s_valid (s_valid),
        .s_data  (s_data),
        .bus     (Conv_bias_in),
        .last    (b_last)
    );

    // State, layer context and registered valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_pw_q  <= 1'b0;
            tile_num_q <= 8'd0;
            tile_idx_q <= 8'd0;
            w_vld_q    <= 1'b0;
            b_vld_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_pw_q  <= mode_pw_d;
            tile_num_q <= tile_num_d;
            tile_idx_q <= tile_idx_d;
            w_vld_q    <= w_vld_d;
            b_vld_q    <= b_vld_d;
        end
    end

    // Next state and tile bookkeeping; a bus-complete pulse follows its last beat by one cycle.
    always_comb begin
        state_d    = state_q;
        mode_pw_d  = mode_pw_q;
        tile_num_d = tile_num_q;
        tile_idx_d = tile_idx_q;
        w_vld_d    = w_last;
        b_vld_d    = b_last;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD_W;
                    mode_pw_d  = mode_pw;
                    tile_num_d = (tile_num == 8'd0) ? 8'd1 : tile_num;
                    tile_idx_d = 8'd0;
                end
            end
            ST_LOAD_W: if (w_last) state_d = ST_LOAD_B;
            ST_LOAD_B: if (b_last) state_d = mode_pw_q ? ST_RUN_PW : ST_RUN_DW;
            ST_RUN_DW, ST_RUN_PW: begin
                if (state_rst) begin
                    if ({1'b0, tile_idx_q} + 9'd1 < {1'b0, tile_num_q}) begin
                        state_d    = ST_LOAD_W;
                        tile_idx_d = tile_idx_q + 8'd1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                tile_idx_d = 8'd0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        w_en          = (state_q == ST_LOAD_W);
        b_en          = (state_q == ST_LOAD_B);
        s_ready       = w_en | b_en;
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_DONE);
        current_state = state_q;
    end

    assign Conv_weight_valid_in = w_vld_q;
    assign Conv_bias_valid_in   = b_vld_q;
    assign tile_idx             = tile_idx_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Randomized bench for conv_layer_sequencer with a beat-array reference model.
module tb_conv_layer_sequencer;
    import conv_layer_sequencer_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst, start, mode_pw, s_valid, state_rst;
    logic [7:0]            tile_num;
    logic [LOAD_WIDTH-1:0] s_data;
    logic                  s_ready, wv, bv, busy, done;
    logic [W_BUS_W-1:0]    wbus;
    logic [B_BUS_W-1:0]    bbus;
    logic [2:0]            cs;
    logic [7:0]            tile_idx;

    always #5 clk = ~clk;

    conv_layer_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .mode_pw              (mode_pw),
        .tile_num             (tile_num),
        .s_data               (s_data),
        .s_valid              (s_valid),
        .s_ready              (s_ready),
        .Conv_weight_in       (wbus),
        .Conv_weight_valid_in (wv),
        .Conv_bias_in         (bbus),
        .Conv_bias_valid_in   (bv),
        .current_state        (cs),
        .state_rst            (state_rst),
        .tile_idx             (tile_idx),
        .busy                 (busy),
        .done                 (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [W_BUS_W-1:0] got, input logic [W_BUS_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Mid-cycle monitor: pulse counts, over-long pulses and handshakes.
    int   w_pulses = 0, b_pulses = 0, done_pulses = 0, long_pulses = 0, accepts = 0;
    logic wv_prev = 1'b0, bv_prev = 1'b0, done_prev = 1'b0;
    always @(negedge clk) begin
        if (wv) w_pulses++;
        if (bv) b_pulses++;
        if (done) done_pulses++;
        if ((wv && wv_prev) || (bv && bv_prev) || (done && done_prev)) long_pulses++;
        if (s_valid && s_ready) accepts++;
        wv_prev   = wv;
        bv_prev   = bv;
        done_prev = done;
    end

    logic [LOAD_WIDTH-1:0] wb [W_BEATS];
    logic [LOAD_WIDTH-1:0] bb [B_BEATS];
    bit det_data = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LOAD_WIDTH-1:0] rand_beat();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[LOAD_WIDTH-1:0];
    endfunction

    // Offer n beats from the weight or bias model array with random gaps.
    task automatic send(input int n, input bit is_w, input int gap);
        int k = 0;
        int guard = 0;
        bit acc;
        while (k < n && guard < 1000) begin
            s_valid = ($urandom_range(99) >= gap);
            if (s_valid) s_data = is_w ? wb[k] : bb[k];
            else         s_data = rand_beat();
            acc = s_valid && s_ready;
            tick();
            if (acc) k++;
            guard++;
        end
        s_valid = 1'b0;
        if (k != n) check_eq("send_timeout", W_BUS_W'(k), W_BUS_W'(n));
    endtask

    task automatic run_tile(input int t, input bit last_tile, input bit pw, input int gap, input bit spurious);
        logic [W_BUS_W-1:0] exp_w, hold_w;
        logic [B_BUS_W-1:0] exp_b;
        int a0;
        for (int k = 0; k < W_BEATS; k++) wb[k] = det_data ? LOAD_WIDTH'(k) : rand_beat();
        for (int k = 0; k < B_BEATS; k++) bb[k] = det_data ? LOAD_WIDTH'(8'hA0 + k) : rand_beat();
        exp_w = '0;
        exp_b = '0;
        for (int k = 0; k < W_BEATS; k++) exp_w[k*LOAD_WIDTH +: LOAD_WIDTH] = wb[k];
        for (int k = 0; k < B_BEATS; k++) exp_b[k*LOAD_WIDTH +: LOAD_WIDTH] = bb[k];

        check_eq("tile_idx", tile_idx, t);
        if (spurious) begin
            state_rst = 1'b1;
            tick();
            state_rst = 1'b0;
            check_eq("state_rst_in_loadw", cs, 1);
        end
        a0 = accepts;
        send(W_BEATS, 1'b1, gap);
        check_eq("w_pulse", wv, 1);
        check_eq("state_load_b", cs, 2);
        check_eq("ready_no_bubble", s_ready, 1);
        check_eq("weight_bus", wbus, exp_w);
        send(B_BEATS, 1'b0, gap);
        check_eq("b_pulse", bv, 1);
        check_eq("w_pulse_gone", wv, 0);
        check_eq("state_run", cs, pw ? 4 : 3);
        check_eq("bias_bus", bbus, W_BUS_W'(exp_b));
        check_eq("beats_consumed", W_BUS_W'(accepts - a0), W_BEATS + B_BEATS);

        hold_w  = wbus;
        s_valid = 1'b1;
        s_data  = rand_beat();
        repeat (3) tick();
        check_eq("run_ready_low", s_ready, 0);
        check_eq("run_bus_stable", wbus, hold_w);
        check_eq("run_bias_stable", bbus, W_BUS_W'(exp_b));
        check_eq("b_pulse_gone", bv, 0);
        if (spurious) begin
            start    = 1'b1;
            mode_pw  = ~pw;
            tile_num = 8'd7;
            tick();
            start = 1'b0;
            check_eq("start_in_run", cs, pw ? 4 : 3);
        end
        s_valid   = 1'b0;
        state_rst = 1'b1;
        tick();
        state_rst = 1'b0;
        if (!last_tile) begin
            check_eq("next_tile_state", cs, 1);
            check_eq("next_tile_idx", tile_idx, t + 1);
        end else begin
            check_eq("done_state", cs, 5);
            check_eq("done_pulse", done, 1);
        end
    endtask

    task automatic run_layer(input bit pw, input logic [7:0] tn, input int gap, input bit spurious);
        int nt = (tn == 8'd0) ? 1 : int'(tn);
        int w0 = w_pulses, b0 = b_pulses, d0 = done_pulses, l0 = long_pulses;
        mode_pw  = pw;
        tile_num = tn;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        mode_pw  = 1'b0;
        tile_num = 8'd0;
        check_eq("start_state", cs, 1);
        check_eq("start_busy", busy, 1);
        check_eq("start_tile_idx", tile_idx, 0);
        for (int t = 0; t < nt; t++) run_tile(t, t == nt - 1, pw, gap, spurious);
        tick();
        check_eq("idle_after_done", cs, 0);
        check_eq("done_cleared", done, 0);
        check_eq("idle_tile_idx", tile_idx, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("w_pulse_count", W_BUS_W'(w_pulses - w0), nt);
        check_eq("b_pulse_count", W_BUS_W'(b_pulses - b0), nt);
        check_eq("done_count", W_BUS_W'(done_pulses - d0), 1);
        check_eq("pulse_width", W_BUS_W'(long_pulses - l0), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; mode_pw = 1'b0; tile_num = 8'd1;
        s_valid = 1'b0; s_data = '0; state_rst = 1'b0;
        repeat (3) tick();
        check_eq("rst_state", cs, 0);
        check_eq("rst_ready", s_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_wv", wv, 0);
        check_eq("rst_bv", bv, 0);
        check_eq("rst_wbus", wbus, 0);
        check_eq("rst_bbus", bbus, 0);
        check_eq("rst_tile_idx", tile_idx, 0);
        rst = 1'b0; start = 1'b0;
        tick();
        check_eq("idle_after_rst", cs, 0);

        state_rst = 1'b1;
        tick();
        state_rst = 1'b0;
        check_eq("state_rst_in_idle", cs, 0);

        det_data = 1'b1;
        run_layer(1'b0, 8'd1, 0, 1'b0);
        det_data = 1'b0;
        run_layer(1'b0, 8'd1, 50, 1'b0);
        run_layer(1'b1, 8'd3, 30, 1'b0);

        mode_pw = 1'b0; tile_num = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < W_BEATS; k++) wb[k] = rand_beat();
        send(7, 1'b1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midload_rst_state", cs, 0);
        check_eq("midload_rst_wbus", wbus, 0);
        check_eq("midload_rst_bbus", bbus, 0);
        check_eq("midload_rst_ready", s_ready, 0);
        run_layer(1'b0, 8'd1, 20, 1'b0);

        run_layer(1'b0, 8'd2, 50, 1'b1);
        run_layer(1'b1, 8'd0, 20, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

endmodule
